// File: rtl/adder_pkg.sv
// Shared constants and types for the pipelined carry-lookahead adder.
// Holds the default geometry, the stage-count helper and the per-bit generate/propagate pair.
package adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_BLOCK = 4;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // WIDTH is expected to be an exact multiple of BLOCK.
  function automatic int calc_stages(input int width, input int block);
    return width / block;
  endfunction

endpackage

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for pipelined_cla_adder.
// The mismatch signal exists only when RC_SELF_CHECK_EN is defined.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = adder_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             cout;
  logic             ovf;

`ifdef RC_SELF_CHECK_EN
  logic             mismatch;

  modport master (
    output in_valid, in1, in2, cin, out_ready,
    input  in_ready, out_valid, out, cout, ovf, mismatch
  );

  modport slave (
    input  in_valid, in1, in2, cin, out_ready,
    output in_ready, out_valid, out, cout, ovf, mismatch
  );
`else
  modport master (
    output in_valid, in1, in2, cin, out_ready,
    input  in_ready, out_valid, out, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, out_ready,
    output in_ready, out_valid, out, cout, ovf
  );
`endif

endinterface

// File: rtl/cla_slice.sv
// Combinational BLOCK-bit carry-lookahead slice.
// Every carry is the fully expanded sum of generate terms, so no ripple path exists inside the slice.
module cla_slice
  import adder_pkg::*;
#(
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out
);

  gp_t  [BLOCK-1:0] gp;
  logic [BLOCK:0]   c;

  genvar gi;
  generate
    for (gi = 0; gi < BLOCK; gi++) begin : g_bit
      assign gp[gi] = '{g: a[gi] & b[gi], p: a[gi] ^ b[gi]};
      assign s[gi]  = gp[gi].p ^ c[gi];
    end
  endgenerate

  // c[i+1] = c_in&p[0..i] | g[0]&p[1..i] | ... | g[i]
  always_comb begin
    logic term;
    c    = '0;
    term = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < BLOCK; i++) begin
      term = c_in;
      for (int m = 0; m <= i; m++) begin
        term = term & gp[m].p;
      end
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = gp[j].g;
        for (int m = j + 1; m <= i; m++) begin
          term = term & gp[m].p;
        end
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign c_out = c[BLOCK];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Carry-pipelined adder: one BLOCK-bit CLA slice per stage, global stall on output backpressure.
// Define RC_SELF_CHECK_EN to carry a ripple-carry reference sum and expose a mismatch flag.
module pipelined_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int BLOCK = DEFAULT_BLOCK
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);

  localparam int STAGES = calc_stages(WIDTH, BLOCK);

  logic adv;
  logic accept;
  logic out_valid_q;

  assign adv         = bus.out_ready | ~out_valid_q;
  assign accept      = bus.in_valid & adv;
  assign bus.in_ready = adv;

`ifdef RC_SELF_CHECK_EN
  // Plain ripple reference {cout, sum} of the operands presented this cycle.
  logic [WIDTH:0] rc_sum;

  always_comb begin
    logic rc_carry;
    rc_sum   = '0;
    rc_carry = bus.cin;
    for (int i = 0; i < WIDTH; i++) begin
      rc_sum[i] = bus.in1[i] ^ bus.in2[i] ^ rc_carry;
      rc_carry  = (bus.in1[i] & bus.in2[i]) | (rc_carry & (bus.in1[i] ^ bus.in2[i]));
    end
    rc_sum[WIDTH] = rc_carry;
  end
`endif

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stg
      localparam int HI  = (gi + 1) * BLOCK;
      localparam int REM = WIDTH - HI;

      logic [BLOCK-1:0] sl_a;
      logic [BLOCK-1:0] sl_b;
      logic [BLOCK-1:0] sl_s;
      logic             sl_c;
      logic             sl_co;
      logic             ld;
      logic             valid_next;
      logic             a_msb_next;
      logic             b_msb_next;
      logic [HI-1:0]    sum_next;

      logic             valid_reg;
      logic             carry_reg;
      logic             a_msb_reg;
      logic             b_msb_reg;
      logic [HI-1:0]    sum_reg;
`ifdef RC_SELF_CHECK_EN
      logic [WIDTH:0]   ref_next;
`endif

      cla_slice #(.BLOCK(BLOCK)) u_slice (
        .a     (sl_a),
        .b     (sl_b),
        .c_in  (sl_c),
        .s     (sl_s),
        .c_out (sl_co)
      );

      if (gi == 0) begin : g_src
        assign ld         = accept;
        assign valid_next = accept;
        assign sl_a       = bus.in1[BLOCK-1:0];
        assign sl_b       = bus.in2[BLOCK-1:0];
        assign sl_c       = bus.cin;
        assign a_msb_next = bus.in1[WIDTH-1];
        assign b_msb_next = bus.in2[WIDTH-1];
        assign sum_next   = sl_s;
`ifdef RC_SELF_CHECK_EN
        assign ref_next   = rc_sum;
`endif
      end else begin : g_src
        // Later stages copy on every advance; bubbles simply travel with valid=0.
        assign ld         = 1'b1;
        assign valid_next = stg[gi-1].valid_reg;
        assign sl_a       = stg[gi-1].g_rem.a_rem_reg[BLOCK-1:0];
        assign sl_b       = stg[gi-1].g_rem.b_rem_reg[BLOCK-1:0];
        assign sl_c       = stg[gi-1].carry_reg;
        assign a_msb_next = stg[gi-1].a_msb_reg;
        assign b_msb_next = stg[gi-1].b_msb_reg;
        assign sum_next   = {sl_s, stg[gi-1].sum_reg};
`ifdef RC_SELF_CHECK_EN
        assign ref_next   = stg[gi-1].g_rem.ref_reg;
`endif
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          a_msb_reg <= 1'b0;
          b_msb_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (adv) begin
          valid_reg <= valid_next;
          if (ld) begin
            sum_reg   <= sum_next;
            carry_reg <= sl_co;
            a_msb_reg <= a_msb_next;
            b_msb_reg <= b_msb_next;
          end
        end
      end

      // Operand bits still waiting for a slice; the last stage has none left.
      if (REM > 0) begin : g_rem
        logic [REM-1:0] a_rem_next;
        logic [REM-1:0] b_rem_next;
        logic [REM-1:0] a_rem_reg;
        logic [REM-1:0] b_rem_reg;
`ifdef RC_SELF_CHECK_EN
        logic [WIDTH:0] ref_reg;
`endif

        if (gi == 0) begin : g_load
          assign a_rem_next = bus.in1[WIDTH-1:BLOCK];
          assign b_rem_next = bus.in2[WIDTH-1:BLOCK];
        end else begin : g_load
          assign a_rem_next = stg[gi-1].g_rem.a_rem_reg[REM+BLOCK-1:BLOCK];
          assign b_rem_next = stg[gi-1].g_rem.b_rem_reg[REM+BLOCK-1:BLOCK];
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            a_rem_reg <= '0;
            b_rem_reg <= '0;
`ifdef RC_SELF_CHECK_EN
            ref_reg   <= '0;
`endif
          end else if (adv && ld) begin
            a_rem_reg <= a_rem_next;
            b_rem_reg <= b_rem_next;
`ifdef RC_SELF_CHECK_EN
            ref_reg   <= ref_next;
`endif
          end
        end
      end
    end
  endgenerate

  assign out_valid_q   = stg[STAGES-1].valid_reg;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = stg[STAGES-1].sum_reg;
  assign bus.cout      = stg[STAGES-1].carry_reg;
  assign bus.ovf       = (stg[STAGES-1].a_msb_reg == stg[STAGES-1].b_msb_reg) &
                         (stg[STAGES-1].sum_reg[WIDTH-1] != stg[STAGES-1].a_msb_reg);

`ifdef RC_SELF_CHECK_EN
  // Compared as the final stage loads, so the flag lines up with out_valid.
  logic mismatch_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_reg <= 1'b0;
    end else if (adv) begin
      mismatch_reg <= stg[STAGES-1].valid_next &
                      ({stg[STAGES-1].sl_co, stg[STAGES-1].sum_next} != stg[STAGES-1].ref_next);
`ifndef SYNTHESIS
      if (stg[STAGES-1].valid_next &&
          ({stg[STAGES-1].sl_co, stg[STAGES-1].sum_next} != stg[STAGES-1].ref_next)) begin
        $display("pipelined_cla_adder: cla=%0h ripple=%0h",
                 {stg[STAGES-1].sl_co, stg[STAGES-1].sum_next}, stg[STAGES-1].ref_next);
      end
`endif
    end
  end

  assign bus.mismatch = mismatch_reg;
`endif

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, carry-pipelined adder built from BLOCK-bit carry-lookahead slices.
- One slice is evaluated per pipeline stage. The carry is registered between stages, so latency is WIDTH/BLOCK cycles and throughput is one addition per cycle.
- Uses a valid/ready handshake on both sides with backpressure.
- Next-generation arithmetic unit for the datapath; supersedes the fixed 4-bit combinational CLA/ripple pair.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of BLOCK.
- BLOCK, 4, width of one CLA slice (bits added per stage).
- STAGES, WIDTH/BLOCK, derived local parameter; number of pipeline stages, equal to latency in cycles.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands present on in1/in2/cin.
- in_ready  output  1  block accepts operands this cycle.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result present on out/cout/ovf.
- out_ready  input  1  downstream accepts the result.
- out  output  WIDTH  sum (in1 + in2 + cin) mod 2^WIDTH.
- cout  output  1  carry out of the MSB.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - Sampled on the rising edge when rst=1.
  - Clears all stage valid bits, partial sums, carries and operand shift registers to 0.
  - out=0, cout=0, ovf=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards every in-flight operation; no result is emitted for them.
- Advance condition: adv = out_ready | ~out_valid.
  - The whole pipeline shifts by one stage on every edge where adv=1 (global stall; bubbles are not collapsed).
  - in_ready = adv, combinational.
  - Accept = in_valid & in_ready.
- Stage 0:
  - Captures in1, in2 and cin on accept.
  - Slice 0 (bits BLOCK-1:0) is added combinationally in the same cycle.
  - Stage 0 registers: sum bits, carry, the unprocessed upper operand bits, and the operand MSBs for overflow.
  - A cycle with adv=1 and no accept loads a bubble (valid=0).
- Stage k (1..STAGES-1):
  - Adds slice k of the carried operands plus the registered carry.
  - Appends the result bits to the partial sum and registers the new carry.
- Output:
  - The final stage registers drive out, cout and out_valid directly; there is no combinational path from in1/in2 to out.
  - ovf = (a_msb == b_msb) & (out[WIDTH-1] != a_msb).
- Latency: a result appears exactly STAGES cycles after acceptance when never stalled. Each stall cycle adds one cycle.
- Stall: while out_valid=1 and out_ready=0, all stage registers and out/cout/ovf/out_valid hold, and in_ready=0.
- Simultaneous events: out_ready=1 with in_valid=1 in the same cycle retires the output and accepts new operands on that edge (full throughput).
- WIDTH == BLOCK gives STAGES=1, a single registered CLA.
- Arithmetic:
  - Widths are unsigned internally.
  - Carry chain within a slice is lookahead: g = a&b, p = a^b, c[i+1] = g[i] | p[i]&c[i], expanded.
  - Wrap-around modulo 2^WIDTH; cout reports the lost bit.

Optional Feature:
- Macro RC_SELF_CHECK_EN.
- Defined:
  - A full-width ripple-carry reference sum {cout,out} is computed at accept.
  - It is carried alongside the pipeline and compared when out_valid=1.
  - Adds output port mismatch (1 bit, registered, reset 0). It is set for a cycle where a valid output differs from the reference, and is 0 otherwise.
  - Simulation additionally issues $display on a mismatch.
- Undefined: no reference logic and no mismatch port; area and timing are unaffected.

Decomposition:
- Shared package adder_pkg:
  - Default WIDTH/BLOCK constants.
  - A function computing STAGES.
  - A generate/propagate struct or typedef for one slice.
- One natural sub-module: cla_slice.
  - Combinational, BLOCK-bit.
  - Inputs a, b, c_in; outputs s, c_out.
  - Instantiated STAGES times by generate.
- The optional ripple reference reuses the existing rc_adder behaviour, generalised to WIDTH.

Test Plan (WIDTH=16, BLOCK=4, STAGES=4):
- 0x0002 + 0xFFFE, cin=0, out_ready=1 -> out=0x0000, cout=1, ovf=0, out_valid exactly 4 cycles after accept.
- 0x7FFF + 0x0001, cin=0 -> out=0x8000, cout=0, ovf=1; then 0xFFFF + 0x0000, cin=1 -> out=0x0000, cout=1, ovf=0.
- Four back-to-back accepts (0x0002+0x000A, 0x0002+0x0007, 0x0006+0x0006, 0x1234+0x4321) -> results 0x000C, 0x0009, 0x000C, 0x5555 on four consecutive cycles, in order, with in_ready held at 1.
- Stall: out_ready=0 for 3 cycles while out_valid=1 -> out/cout/ovf stable, in_ready=0, no operand lost or duplicated; releasing out_ready resumes in order.
- Reset after two accepts (before either result) -> out_valid stays 0, out=0, no stale result; the next accept yields a correct sum after 4 cycles.
- RC_SELF_CHECK_EN defined, 1000 random operands including cin toggling -> mismatch never asserted; out matches (in1+in2+cin) mod 2^16 for every transaction.
